// File: rtl/ifetch.sv
// Instruction fetch unit: owns the PC, issues one instruction-memory read at a
// time and holds the returned word for decode under a valid/ready handshake.
module ifetch #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    // instruction memory request channel
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    // instruction memory response channel
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    // decode handshake
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [6:0]      if_opcode,
    // branch/jump redirect
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     fetch_count
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            discard_q, discard_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] ifpc_q, ifpc_d;
    logic [31:0]     count_q, count_d;
    logic [XLEN-1:0] redirect_tgt;

    assign redirect_tgt = redirect_pc & ~XLEN'(3);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        instr_d   = instr_q;
        ifpc_d    = ifpc_q;
        count_d   = count_q;

        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_req_ready) begin
                    state_d = WAIT;
                    // The word already requested belongs to the old PC.
                    if (redirect_valid) discard_d = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_d   = REQ;
                    discard_d = 1'b0;
                    if (!discard_q && !redirect_valid) begin
                        instr_d = imem_rsp_data;
                        ifpc_d  = pc_q;
                        state_d = HOLD;
                    end
                end else if (redirect_valid) begin
                    discard_d = 1'b1;
                end
            end
            HOLD: begin
                if (if_ready) begin
                    count_d = count_q + 32'd1;
                    pc_d    = pc_q + XLEN'(4);
                    state_d = REQ;
                end
                // Without if_ready this flushes the held word.
                if (redirect_valid) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase

        // A redirect beats the sequential increment in every state.
        if (redirect_valid) pc_d = redirect_tgt;
    end

    // NOTE: datapath registers are reset too, so decode never sees X after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
            instr_q   <= '0;
            ifpc_q    <= '0;
            count_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            instr_q   <= instr_d;
            ifpc_q    <= ifpc_d;
            count_q   <= count_d;
        end
    end

    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = pc_q;
    assign if_valid       = (state_q == HOLD);
    assign if_instr       = instr_q;
    assign if_pc          = ifpc_q;
    assign if_opcode      = instr_q[6:0];
    assign fetch_count    = count_q;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios followed by a randomized
// run checked against an architectural PC / delivery-count model.
module tb_ifetch;

    localparam int unsigned XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [6:0]  if_opcode;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    // memory environment
    int          rsp_delay = 0;
    bit          rsp_rand = 1'b0;
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    int          req_cnt = 0;
    int          rsp_pulses = 0;
    bit          fire_s;
    logic [31:0] addr_s;

    ifetch #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_opcode      (if_opcode),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h0000_0463;
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    // One response pulse per accepted request, after a programmable delay.
    always @(posedge clk) begin
        fire_s = imem_req_valid && imem_req_ready;
        addr_s = imem_req_addr;
        if (fire_s) req_cnt++;
        #1;
        imem_rsp_valid = 1'b0;
        if (fire_s) begin
            pend      = 1'b1;
            pend_addr = addr_s;
            pend_cnt  = rsp_rand ? int'($urandom_range(0, 3)) : rsp_delay;
        end
        if (pend) begin
            if (pend_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_addr);
                pend           = 1'b0;
                rsp_pulses++;
            end else begin
                pend_cnt--;
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_if_valid(input int bound, input string name);
        int n;
        n = 0;
        while (!if_valid && n < bound) begin
            step();
            n++;
        end
        checks++;
        if (!if_valid) begin
            errors++;
            $display("FAIL %s: if_valid not seen within %0d cycles", name, bound);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== RESET_PC || if_valid !== 1'b0 ||
            if_instr !== 32'h0 || if_pc !== 32'h0 || if_opcode !== 7'h0 || fetch_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_values: req_valid=%b addr=%h if_valid=%b instr=%h pc=%h op=%h cnt=%0d, expected all zero/RESET_PC",
                     imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_opcode, fetch_count);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_request: req_valid=%b addr=%h if_valid=%b, expected 1 %h 0",
                     imem_req_valid, imem_req_addr, if_valid, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;
        rsp_delay      = 0;
        for (int i = 0; i < 2; i++) begin
            logic [31:0] a;
            logic [6:0]  op;
            a  = 32'(i * 4);
            op = (i == 0) ? 7'b0010011 : 7'b1100011;
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== a || fetch_count !== 32'(i)) begin
                errors++;
                $display("FAIL seq_req%0d: valid=%b addr=%h cnt=%0d, expected 1 %h %0d",
                         i, imem_req_valid, imem_req_addr, fetch_count, a, i);
            end
            step();
            checks++;
            if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
                errors++;
                $display("FAIL seq_wait%0d: req_valid=%b if_valid=%b, expected 0 0", i, imem_req_valid, if_valid);
            end
            step();
            checks++;
            if (if_valid !== 1'b1 || if_pc !== a || if_opcode !== op || if_instr !== mem_word(a)) begin
                errors++;
                $display("FAIL seq_deliver%0d: valid=%b pc=%h op=%b instr=%h, expected 1 %h %b %h",
                         i, if_valid, if_pc, if_opcode, if_instr, a, op, mem_word(a));
            end
            step();
        end
        if_ready = 1'b0;
        checks++;
        if (fetch_count !== 32'd2 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin
            errors++;
            $display("FAIL seq_count: cnt=%0d valid=%b addr=%h, expected 2 1 00000008",
                     fetch_count, imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_backpressure();
        int rc;
        wait_if_valid(10, "bp_arrive");
        rc = req_cnt;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== mem_word(32'h8) || imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b pc=%h instr=%h req=%b, expected 1 00000008 %h 0",
                         i, if_valid, if_pc, if_instr, imem_req_valid, mem_word(32'h8));
            end
            step();
        end
        checks++;
        if (req_cnt !== rc) begin
            errors++;
            $display("FAIL bp_no_req: accepted=%0d, expected %0d", req_cnt, rc);
        end
        imem_req_ready = 1'b0;
        if_ready       = 1'b1;
        step();
        if_ready = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hC || fetch_count !== 32'd3) begin
            errors++;
            $display("FAIL bp_release: valid=%b addr=%h cnt=%0d, expected 1 0000000c 3",
                     imem_req_valid, imem_req_addr, fetch_count);
        end
    endtask

    task automatic test_mem_stall();
        int rc;
        rc        = req_cnt;
        rsp_delay = 4;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hC) begin
                errors++;
                $display("FAIL stall_addr%0d: valid=%b addr=%h, expected 1 0000000c", i, imem_req_valid, imem_req_addr);
            end
            step();
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        if_ready       = 1'b1;
        wait_if_valid(20, "stall_arrive");
        checks++;
        if (if_pc !== 32'hC || if_instr !== mem_word(32'hC)) begin
            errors++;
            $display("FAIL stall_deliver: pc=%h instr=%h, expected 0000000c %h", if_pc, if_instr, mem_word(32'hC));
        end
        step();
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (req_cnt !== rc + 1 || fetch_count !== 32'd4 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin
            errors++;
            $display("FAIL stall_once: accepted=%0d cnt=%0d valid=%b addr=%h, expected %0d 4 1 00000010",
                     req_cnt, fetch_count, imem_req_valid, imem_req_addr, rc + 1);
        end
    endtask

    task automatic test_redirect_wait();
        bit saw_valid;
        int n;
        rsp_delay      = 2;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h101;
        step();
        redirect_valid = 1'b0;
        saw_valid      = 1'b0;
        n              = 0;
        while (!imem_req_valid && n < 20) begin
            if (if_valid) saw_valid = 1'b1;
            step();
            n++;
        end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100 || saw_valid || fetch_count !== 32'd4) begin
            errors++;
            $display("FAIL redir_wait: valid=%b addr=%h saw_if_valid=%b cnt=%0d, expected 1 00000100 0 4",
                     imem_req_valid, imem_req_addr, saw_valid, fetch_count);
        end
    endtask

    task automatic test_redirect_hold();
        rsp_delay      = 0;
        if_ready       = 1'b0;
        imem_req_ready = 1'b1;
        wait_if_valid(10, "rh_arrive");
        checks++;
        if (if_pc !== 32'h100 || if_instr !== mem_word(32'h100)) begin
            errors++;
            $display("FAIL rh_target: pc=%h instr=%h, expected 00000100 %h", if_pc, if_instr, mem_word(32'h100));
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40 || fetch_count !== 32'd4) begin
            errors++;
            $display("FAIL rh_flush: if_valid=%b req=%b addr=%h cnt=%0d, expected 0 1 00000040 4",
                     if_valid, imem_req_valid, imem_req_addr, fetch_count);
        end
        wait_if_valid(10, "rh_arrive2");
        checks++;
        if (if_pc !== 32'h40) begin
            errors++;
            $display("FAIL rh_pc2: pc=%h, expected 00000040", if_pc);
        end
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        checks++;
        if (fetch_count !== 32'd5 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin
            errors++;
            $display("FAIL rh_complete: cnt=%0d req=%b addr=%h, expected 5 1 00000040",
                     fetch_count, imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_async_reset();
        int pulses;
        bit bad;
        rsp_delay      = 5;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL ar_in_wait: req=%b if_valid=%b, expected 0 0", imem_req_valid, if_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== RESET_PC || if_valid !== 1'b0 ||
            if_instr !== 32'h0 || if_pc !== 32'h0 || if_opcode !== 7'h0 || fetch_count !== 32'h0) begin
            errors++;
            $display("FAIL ar_immediate: req=%b addr=%h if_valid=%b instr=%h pc=%h cnt=%0d, expected reset values",
                     imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, fetch_count);
        end
        pulses = rsp_pulses;
        step();
        rst_n = 1'b1;
        bad   = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (if_valid || (imem_req_valid && imem_req_addr !== RESET_PC)) bad = 1'b1;
        end
        checks++;
        if (bad || rsp_pulses == pulses || fetch_count !== 32'h0) begin
            errors++;
            $display("FAIL ar_late_rsp: disturbed=%b late_pulses=%0d cnt=%0d, expected 0 >0 0",
                     bad, rsp_pulses - pulses, fetch_count);
        end
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;
        rsp_delay      = 0;
        wait_if_valid(10, "ar_refetch");
        checks++;
        if (if_pc !== RESET_PC || if_instr !== mem_word(RESET_PC)) begin
            errors++;
            $display("FAIL ar_first: pc=%h instr=%h, expected %h %h", if_pc, if_instr, RESET_PC, mem_word(RESET_PC));
        end
        step();
        checks++;
        if (fetch_count !== 32'd1) begin
            errors++;
            $display("FAIL ar_count: cnt=%0d, expected 1", fetch_count);
        end
    endtask

    // Architectural model: the PC advances by 4 per delivered instruction and
    // is overwritten by any redirect; every request and delivery uses it.
    task automatic test_random();
        logic [31:0] exp_pc, exp_count, prev_pc, prev_instr, prev_addr;
        bit prev_if_hold, prev_req_hold;
        int delivered;
        exp_pc        = RESET_PC + 32'd4;
        exp_count     = 32'd1;
        prev_if_hold  = 1'b0;
        prev_req_hold = 1'b0;
        prev_pc       = '0;
        prev_instr    = '0;
        prev_addr     = '0;
        delivered     = 0;
        rsp_rand      = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            checks++;
            if (fetch_count !== exp_count || (imem_req_valid && if_valid)) begin
                errors++;
                $display("FAIL rnd_count@%0d: cnt=%0d req=%b if_valid=%b, expected %0d, not both valid",
                         cyc, fetch_count, imem_req_valid, if_valid, exp_count);
            end
            if (imem_req_valid) begin
                checks++;
                if (imem_req_addr !== exp_pc) begin
                    errors++;
                    $display("FAIL rnd_req_addr@%0d: addr=%h, expected %h", cyc, imem_req_addr, exp_pc);
                end
            end
            if (if_valid) begin
                checks++;
                if (if_pc !== exp_pc || if_instr !== mem_word(exp_pc) || if_opcode !== if_instr[6:0]) begin
                    errors++;
                    $display("FAIL rnd_deliver@%0d: pc=%h instr=%h op=%b, expected %h %h %b",
                             cyc, if_pc, if_instr, if_opcode, exp_pc, mem_word(exp_pc), if_instr[6:0]);
                end
            end
            if (prev_if_hold) begin
                checks++;
                if (if_valid !== 1'b1 || if_pc !== prev_pc || if_instr !== prev_instr) begin
                    errors++;
                    $display("FAIL rnd_if_stable@%0d: valid=%b pc=%h instr=%h, expected 1 %h %h",
                             cyc, if_valid, if_pc, if_instr, prev_pc, prev_instr);
                end
            end
            if (prev_req_hold) begin
                checks++;
                if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr) begin
                    errors++;
                    $display("FAIL rnd_req_stable@%0d: valid=%b addr=%h, expected 1 %h",
                             cyc, imem_req_valid, imem_req_addr, prev_addr);
                end
            end

            imem_req_ready = ($urandom_range(0, 2) != 0);
            if_ready       = ($urandom_range(0, 1) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = $urandom;

            if (if_valid && if_ready) begin
                exp_count = exp_count + 32'd1;
                exp_pc    = exp_pc + 32'd4;
                delivered++;
            end
            if (redirect_valid) exp_pc = redirect_pc & ~32'd3;
            prev_if_hold  = if_valid && !if_ready && !redirect_valid;
            prev_req_hold = imem_req_valid && !imem_req_ready && !redirect_valid;
            prev_pc       = if_pc;
            prev_instr    = if_instr;
            prev_addr     = imem_req_addr;
            step();
        end
        redirect_valid = 1'b0;
        checks++;
        if (delivered < 50) begin
            errors++;
            $display("FAIL rnd_progress: delivered=%0d, expected at least 50", delivered);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_mem_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit: owns the program counter and supplies 32-bit instructions, with their PC and opcode field, to the decode stage that drives `control`. It issues one read at a time to instruction memory over a valid/ready request channel, receives the word on a response channel, and holds it for decode under a valid/ready handshake. Branch and jump resolution redirects the PC through `redirect_valid`/`redirect_pc`. The unit is non-pipelined, with at most one outstanding memory request.

## Interface
- `XLEN`, 32: address and instruction width.
- `RESET_PC`, 32'h0000_0000: PC value after reset.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  XLEN  fetch address; equals the current PC.
- `imem_rsp_valid`  in  1  read data valid; one pulse per accepted request.
- `imem_rsp_data`  in  XLEN  instruction word.
- `if_valid`  out  1  instruction available to decode.
- `if_ready`  in  1  decode accepts the instruction.
- `if_instr`  out  XLEN  held instruction word.
- `if_pc`  out  XLEN  PC of `if_instr`.
- `if_opcode`  out  7  `if_instr[6:0]`; connects to `control.opcode`.
- `redirect_valid`  in  1  single-cycle PC redirect from branch/jump resolution.
- `redirect_pc`  in  XLEN  redirect target; bits [1:0] are cleared internally.
- `fetch_count`  out  32  count of instructions delivered to decode; wraps.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD.
- **IDLE**
  - Entered only from reset.
  - Goes to REQ on the first clock edge after `rst_n` rises.
- **REQ**
  - `imem_req_valid`=1 and `imem_req_addr`=pc.
  - On `imem_req_ready`=1, go to WAIT.
- **WAIT**
  - Wait for `imem_rsp_valid`.
  - On the response, latch `imem_rsp_data` into `if_instr`, latch pc into `if_pc`, and go to HOLD.
  - If `discard`=1, drop the response instead, clear `discard`, and go to REQ.
- **HOLD**
  - `if_valid`=1.
  - On `if_ready`=1: `fetch_count`+=1, pc <= pc+4 (modulo 2^XLEN), go to REQ.
- **Redirect** (`redirect_valid`=1); pc <= {`redirect_pc`[XLEN-1:2], 2'b00} in every case below.
  - IDLE: pc is updated; the state still advances to REQ.
  - REQ without `imem_req_ready`: the address changes next cycle while valid stays 1. This is the only permitted address change on an unaccepted request.
  - REQ with `imem_req_ready` in the same cycle: the request issued with the old address is stale. Go to WAIT with `discard`=1.
  - WAIT: set `discard`=1, unless `imem_rsp_valid` is also 1 in that cycle. In that case drop the response and go directly to REQ.
  - HOLD without `if_ready`: the held instruction is flushed. `if_valid`=0 next cycle, go to REQ, `fetch_count` unchanged.
  - HOLD with `if_ready`: the transfer completes and `fetch_count` increments. Redirect wins for the next PC (`redirect_pc`, not pc+4).
- Ignored inputs:
  - `imem_rsp_valid` outside WAIT.
  - `if_ready` outside HOLD.
- `if_opcode` is combinational from `if_instr`.

## Timing
- Reset values (asserted asynchronously):
  - state=IDLE, pc=`RESET_PC`, `discard`=0.
  - `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`.
  - `if_valid`=0, `if_instr`=0, `if_pc`=0, `if_opcode`=0.
  - `fetch_count`=0.
- Reset asserted mid-operation: all of the above takes effect immediately. Any outstanding memory response arriving after reset is ignored, because the unit is in IDLE.
- `imem_req_valid` and `if_valid` are registered-state decodes; no combinational path from inputs to them.
- Minimum latency with zero-wait memory (`imem_req_ready`=1, response one cycle after acceptance): request in cycle N, response in N+1, `if_valid` in N+2.
- Peak throughput: one instruction per 3 cycles.
- `if_instr`, `if_pc` and `if_valid` are stable while `if_valid`=1 and `if_ready`=0, except on a redirect flush.
- `imem_req_addr` is stable while `imem_req_valid`=1 and `imem_req_ready`=0, except on redirect.
- `fetch_count` wraps from 32'hFFFF_FFFF to 0.

## Test plan
- Reset and sequential fetch:
  - Stimulus: release `rst_n`; zero-wait memory returning 32'h00500093 at 0x0, 32'h00000463 at 0x4; `if_ready`=1.
  - Response: requests to 0x0 then 0x4; `if_opcode`=7'b0010011 then 7'b1100011; `if_pc`=0x0 then 0x4; `fetch_count`=2.
- Backpressure:
  - Stimulus: hold `if_ready`=0 for 5 cycles in HOLD with the instruction from 0x8.
  - Response: `if_valid`=1 and `if_instr`/`if_pc`=0x8 constant; no new request issued; pc=0xC after `if_ready` rises.
- Memory stall:
  - Stimulus: `imem_req_ready`=0 for 3 cycles, then 1; response delayed 4 cycles.
  - Response: `imem_req_addr` stable throughout; exactly one request accepted; instruction delivered once.
- Redirect in WAIT:
  - Stimulus: redirect to 0x101 while waiting on 0x10.
  - Response: the 0x10 response is dropped; the next request addr is 0x100; `fetch_count` unchanged.
- Redirect in HOLD:
  - Stimulus 1: redirect to 0x40 with `if_ready`=0.
    - Response: flush; next request 0x40; `fetch_count` unchanged.
  - Stimulus 2: repeat with `if_ready`=1.
    - Response: `fetch_count`+1; next request 0x40.
- Async reset mid-WAIT:
  - Stimulus: pulse `rst_n`=0 between clock edges.
  - Response: outputs reset immediately; a late `imem_rsp_valid` is ignored; the first request goes to `RESET_PC`.
